// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and helpers for the N-way selector pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Select width for an n-way selector, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx_comb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nx_comb
//  Description : Purely combinational N:1 WIDTH-bit selector with range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nx_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]    i_sel,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_err
);

    // Unmatched selects fall through to zero data with the error flag set.
    always_comb begin
        o_data = '0;
        o_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SELW'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
                o_err  = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nx_pipe
//  Description : N-way selector feeding a two-entry skid-buffered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nx_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    generate
        if (N < 2 || N > MAX_N) begin : g_bad_n
            $error("mux_nx_pipe: N must be in 2..16");
        end
    endgenerate

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_acc;
    logic             w_pop;

    skid_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_m_data;
    logic [SELW-1:0]  r_m_sel;
    logic             r_m_err;
    logic [WIDTH-1:0] r_s_data;
    logic [SELW-1:0]  r_s_sel;
    logic             r_s_err;

    mux_nx_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_sel (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_data),
        .o_err  (w_sel_err)
    );

    assign w_acc = in_valid && r_in_ready;
    assign w_pop = r_out_valid && out_ready;

    // Handshake flags are registered alongside the state so that neither
    // ready nor valid has a combinational path from the opposite side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_m_data    <= '0;
            r_m_sel     <= '0;
            r_m_err     <= 1'b0;
            r_s_data    <= '0;
            r_s_sel     <= '0;
            r_s_err     <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_m_data    <= w_sel_data;
                        r_m_sel     <= in_sel;
                        r_m_err     <= w_sel_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_acc && !w_pop) begin
                        r_s_data   <= w_sel_data;
                        r_s_sel    <= in_sel;
                        r_s_err    <= w_sel_err;
                        r_in_ready <= 1'b0;
                        r_state    <= FULL;
                    end else if (w_acc && w_pop) begin
                        r_m_data <= w_sel_data;
                        r_m_sel  <= in_sel;
                        r_m_err  <= w_sel_err;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_m_data   <= r_s_data;
                        r_m_sel    <= r_s_sel;
                        r_m_err    <= r_s_err;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_m_data;
    assign out_sel   = r_m_sel;
    assign out_err   = r_m_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nx_pipe
//  Description : Directed and randomised checks of the selector skid stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_err3;
    logic         out_valid3;
    logic         out_ready3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_nx_pipe #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nx_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   sel;
        logic [31:0]  exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] d, input logic [1:0] s, input logic e);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".data"}, out_data, d);
        chk({name, ".sel"}, {30'd0, out_sel}, {30'd0, s});
        chk({name, ".err"}, {31'd0, out_err}, {31'd0, e});
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    logic [31:0] sb[$];
    logic [31:0] d_exp;
    logic        r_acc;
    logic        r_pop;
    logic        pend;

    initial begin
        tbl[0] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd3, 32'h44};
        tbl[1] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd2, 32'h33};
        tbl[2] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd1, 32'h22};
        tbl[3] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd0, 32'h11};
        tbl[4] = '{{32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 32'h12345678}, 2'd2, 32'hDEADBEEF};
        tbl[5] = '{{32'hFFFFFFFF, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A}, 2'd3, 32'hFFFFFFFF};

        in_data   = '0; in_sel  = '0; in_valid  = 1'b0; out_ready  = 1'b0;
        in_data3  = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.out_sel", {30'd0, out_sel}, 32'd0);
        chk("rst.out_err", {31'd0, out_err}, 32'd0);

        // Streaming, one item per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].data;
            in_sel   = tbl[i].sel;
            chk($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk_out($sformatf("stream%0d", i), tbl[i].exp, tbl[i].sel, 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk("stream.drain", {31'd0, out_valid}, 32'd0);

        // Back-pressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pack4(32'hA0); in_sel = 2'd1;
        step();
        chk_out("bp.A", 32'hA1, 2'd1, 1'b0);
        chk("bp.A.in_ready", {31'd0, in_ready}, 32'd1);
        in_data = pack4(32'hB0); in_sel = 2'd2;
        step();
        chk_out("bp.full", 32'hA1, 2'd1, 1'b0);
        chk("bp.full.in_ready", {31'd0, in_ready}, 32'd0);
        in_data = pack4(32'hC0); in_sel = 2'd0;
        step(); step();
        chk_out("bp.hold", 32'hA1, 2'd1, 1'b0);
        chk("bp.hold.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_out("bp.B", 32'hB2, 2'd2, 1'b0);
        chk("bp.B.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Simultaneous accept and pop while in ONE
        in_valid = 1'b1;
        in_data  = pack4(32'h1000); in_sel = 2'd0;
        step();
        for (int k = 1; k <= 8; k++) begin
            in_data = pack4(32'h1000 * k);
            in_sel  = 2'(k % 4);
            chk($sformatf("simul%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
            step();
            chk_out($sformatf("simul%0d", k), 32'h1000 * k + 32'(k % 4), 2'(k % 4), 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk("simul.drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset from FULL, observed before any clock edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pack4(32'hE0); in_sel = 2'd3;
        step();
        in_data = pack4(32'hF0); in_sel = 2'd1;
        step();
        chk("prerst.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst.out_data", out_data, 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pack4(32'hD0); in_sel = 2'd2;
        step();
        chk_out("arst.first", 32'hD2, 2'd2, 1'b0);
        in_valid = 1'b0;
        step();
        chk("arst.no_stale", {31'd0, out_valid}, 32'd0);

        // Out-of-range select on the three-input instance
        in_valid3 = 1'b1;
        in_data3  = {96{1'b1}};
        in_sel3   = 2'd3;
        step();
        chk("oor.valid", {31'd0, out_valid3}, 32'd1);
        chk("oor.data", out_data3, 32'd0);
        chk("oor.err", {31'd0, out_err3}, 32'd1);
        chk("oor.sel", {30'd0, out_sel3}, 32'd3);
        in_data3 = {32'h32, 32'h31, 32'h30};
        in_sel3  = 2'd2;
        step();
        chk("inr.data", out_data3, 32'h32);
        chk("inr.err", {31'd0, out_err3}, 32'd0);
        chk("inr.sel", {30'd0, out_sel3}, 32'd2);
        in_valid3 = 1'b0;

        // Randomised traffic against a FIFO scoreboard
        sb.delete();
        pend = 1'b0;
        in_valid = 1'b0;
        step();
        for (int c = 0; c < 10000; c++) begin
            if (!pend) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_sel   = 2'($urandom_range(0, 3));
            end
            out_ready = 1'($urandom_range(0, 1));
            chk("rand.in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
            chk("rand.out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
            if (sb.size() > 0) chk("rand.out_data", out_data, sb[0]);
            r_acc = in_valid && (sb.size() < 2);
            r_pop = (sb.size() > 0) && out_ready;
            d_exp = in_data[32*in_sel +: 32];
            step();
            if (r_pop) void'(sb.pop_front());
            if (r_acc) sb.push_back(d_exp);
            pend = in_valid && !r_acc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
